// File: rtl/matrix_serializer_pkg.sv
// ============================================================================
// Module      : matrix_serializer_pkg
// Description : Shared widths, element counts and state type for the
//               normal-matrix serializer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package matrix_serializer_pkg;

  localparam int MATRIX_BW  = 64;
  localparam int MAT_ELEM   = 21;
  localparam int VEC_ELEM   = 6;
  localparam int SER_ELEM   = 27;
  localparam int SER_IDX_BW = 5;

  localparam logic [SER_IDX_BW-1:0] SER_LAST_IDX = SER_IDX_BW'(SER_ELEM - 1);

  typedef enum logic {
    SER_IDLE = 1'b0,
    SER_SEND = 1'b1
  } ser_state_t;

endpackage

`default_nettype wire

// File: rtl/matrix_serializer.sv
// ============================================================================
// Module      : matrix_serializer
// Description : Snapshots the 21 lower-triangle matrix words and 6 vector
//               words on frame end and streams them over valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module matrix_serializer
  import matrix_serializer_pkg::*;
#(
  parameter int DATA_BW = MATRIX_BW
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_frame_end,
  input  logic [MAT_ELEM*DATA_BW-1:0] i_mat,
  input  logic [VEC_ELEM*DATA_BW-1:0] i_vec,
  output logic                        o_valid,
  input  logic                        i_ready,
  output logic [DATA_BW-1:0]          o_data,
  output logic [SER_IDX_BW-1:0]       o_idx,
  output logic                        o_last,
  output logic                        o_busy,
  output logic                        o_overrun
);

  localparam logic [SER_IDX_BW-1:0] c_idx_one = SER_IDX_BW'(1);

  ser_state_t              r_state;
  ser_state_t              w_state_next;
  logic [DATA_BW-1:0]      r_bank    [SER_ELEM];
  logic [DATA_BW-1:0]      w_capture [SER_ELEM];
  logic [SER_IDX_BW-1:0]   w_idx_next;
  logic [DATA_BW-1:0]      w_data_next;
  logic                    w_last_next;
  logic                    w_load;
  logic                    w_overrun_set;
  logic                    w_hs;
  logic                    w_final_hs;

  assign w_hs       = o_valid & i_ready;
  assign w_final_hs = w_hs & (o_idx == SER_LAST_IDX);

  // Flatten the packed ports into serializer order: matrix first, then vector.
  always_comb begin
    for (int k = 0; k < MAT_ELEM; k++) begin
      w_capture[k] = i_mat[k*DATA_BW +: DATA_BW];
    end
    for (int k = 0; k < VEC_ELEM; k++) begin
      w_capture[MAT_ELEM+k] = i_vec[k*DATA_BW +: DATA_BW];
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_idx_next    = o_idx;
    w_load        = 1'b0;
    w_overrun_set = 1'b0;
    case (r_state)
      SER_IDLE: begin
        if (i_frame_end) begin
          w_load       = 1'b1;
          w_idx_next   = '0;
          w_state_next = SER_SEND;
        end
      end
      SER_SEND: begin
        if (w_final_hs) begin
          w_idx_next = '0;
          // A frame ending on the last handshake chains straight into the next stream.
          if (i_frame_end) begin
            w_load = 1'b1;
          end else begin
            w_state_next = SER_IDLE;
          end
        end else if (w_hs) begin
          w_idx_next = o_idx + c_idx_one;
        end
        if (i_frame_end && !w_final_hs) begin
          w_overrun_set = 1'b1;
        end
      end
      default: w_state_next = SER_IDLE;
    endcase
  end

  // Bypass the bank on a load so the first beat carries the fresh capture.
  always_comb begin
    w_data_next = w_load ? w_capture[w_idx_next] : r_bank[w_idx_next];
    w_last_next = (w_state_next == SER_SEND) && (w_idx_next == SER_LAST_IDX);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= SER_IDLE;
      o_valid   <= 1'b0;
      o_busy    <= 1'b0;
      o_idx     <= '0;
      o_last    <= 1'b0;
      o_data    <= '0;
      o_overrun <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      o_valid   <= (w_state_next == SER_SEND);
      o_busy    <= (w_state_next == SER_SEND);
      o_idx     <= w_idx_next;
      o_last    <= w_last_next;
      o_data    <= w_data_next;
      if (w_overrun_set) begin
        o_overrun <= 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_load && !i_rst) begin
      for (int k = 0; k < SER_ELEM; k++) begin
        r_bank[k] <= w_capture[k];
      end
    end
  end

endmodule

`default_nettype wire
